countdown_timer_9bit: RTL and testbench
=======================================

Name: countdown_timer_9bit

Overview:
- Loadable 9-bit down-counter with enable, terminal-count pulse and optional auto-reload.
- It is the counting-down complement of the team's 9-bit up-counter.
- Used as a programmable interval/timeout source: the controller loads a period, enables it, and consumes the terminal-count (tc) pulse or the done level.

Parameters:
- MAX_COUNT, 511: largest loadable value; load values above it are clamped to MAX_COUNT. Legal range is 1..511.
- RESET_VAL, 0: value of cout and of the reload register after reset. Must be ≤ MAX_COUNT.

Ports:
- clk  input  1  system clock; all state changes occur on the rising edge except reset.
- clear_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous load strobe; highest priority after reset.
- load_val  input  9  period to load (clamped to MAX_COUNT).
- enable  input  1  count decrements on each rising edge while high.
- auto_reload  input  1  when high, the counter reloads the stored period on expiry instead of stopping.
- cout  output  9  current count.
- tc  output  1  one-cycle pulse on expiry.
- busy  output  1  high in ARMED or RUN.
- done  output  1  level, high in DONE until the next load or reset.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - cout=RESET_VAL, reload_reg=RESET_VAL, tc=0, busy=0, done=0, state=IDLE.
  - Takes effect immediately, including mid-count.
  - Deassertion is sampled at the next clk edge.
- States: IDLE, ARMED, RUN, DONE. busy and done are decoded from state, registered, with no combinational path from inputs.
- Load priority: load=1 wins over enable in the same cycle; no decrement occurs that cycle.
  - v = min(load_val, MAX_COUNT).
  - reload_reg<=v; cout<=v; tc<=0.
  - Next state is ARMED if v≠0, else IDLE.
  - Load is legal in every state.
- ARMED:
  - enable=1 → cout<=cout−1, state RUN. If cout==1, apply the expiry rule instead.
  - enable=0 → hold.
- RUN:
  - enable=0 → hold cout, state ARMED.
  - enable=1 and cout>1 → cout<=cout−1.
- Expiry (enable=1, cout==1, in ARMED or RUN):
  - tc<=1 for exactly one cycle.
  - If auto_reload=1: cout<=reload_reg, state RUN.
  - If auto_reload=0: cout<=0, state DONE.
  - auto_reload is sampled on the expiry cycle only.
- Period: with auto_reload and enable held high, tc pulses every N cycles for a loaded value N. For N=1, tc is high continuously; this is legal.
- IDLE/DONE with enable=1: no change. cout never underflows below 0 and never wraps to 511.
- tc defaults to 0 every cycle unless an expiry occurs.
- Arithmetic: unsigned 9-bit. Clamp comparison is done on the full 9 bits.
- X on load/enable while clear_n=0 is ignored.

Decomposition:
- Shared package (timer_pkg):
  - COUNT_W=9
  - state encoding constants: IDLE=2'b00, ARMED=2'b01, RUN=2'b10, DONE=2'b11
- Single module; no sub-module needed. Next-state/count logic and registers are kept in separate processes inside the module.

Test Plan:
1. Reset mid-count: load 100, enable 10 cycles (cout=90), pulse clear_n low between edges → cout=0, busy=0, done=0 immediately, no tc.
2. One-shot: load 5, auto_reload=0, enable held → cout 5,4,3,2,1,0. tc high only on the cycle cout becomes 0. done=1 and busy=0 thereafter. Further enables leave cout=0.
3. Auto-reload: load 3, auto_reload=1, enable held 12 cycles → cout 3,2,1,3,2,1,…; tc pulses every 3rd cycle (4 pulses); done stays 0.
4. Pause: load 10, enable 4 cycles (cout=6), enable low 5 cycles → cout holds 6, state ARMED, busy=1. Re-enable → continues 5,4,…
5. Load/enable collision and clamp:
   - With MAX_COUNT=200, at cout=7 assert load=1, load_val=300 with enable=1 → next cout=200, no decrement, tc=0.
   - load_val=0 → cout=0, state IDLE, tc=0.
6. N=1 auto-reload: load 1, auto_reload=1, enable held → cout stays 1, tc high every cycle. Drop auto_reload → next expiry gives cout=0, done=1.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared width and state encoding for the 9-bit countdown timer.
package timer_pkg;
    localparam int COUNT_W = 9;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } state_t;
endpackage

// File: rtl/countdown_timer_9bit.sv
// countdown_timer_9bit: loadable down-counter with terminal-count pulse,
// done level and optional auto-reload of the last loaded period.
module countdown_timer_9bit
    import timer_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 511,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    input  logic               enable,
    input  logic               auto_reload,
    output logic [COUNT_W-1:0] cout,
    output logic               tc,
    output logic               busy,
    output logic               done
);
    localparam logic [COUNT_W-1:0] MAX_V = COUNT_W'(MAX_COUNT);
    localparam logic [COUNT_W-1:0] RST_V = COUNT_W'(RESET_VAL);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cout_q, cout_d, reload_q, reload_d, v;
    logic               tc_q, tc_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cout_d   = cout_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        v        = (load_val > MAX_V) ? MAX_V : load_val;
        if (load) begin
            reload_d = v;
            cout_d   = v;
            state_d  = (v != '0) ? ARMED : IDLE;
        end else if (enable && (state_q == ARMED || state_q == RUN)) begin
            if (cout_q <= COUNT_W'(1)) begin
                // expiry: auto_reload only matters on this cycle
                tc_d    = 1'b1;
                cout_d  = auto_reload ? reload_q : '0;
                state_d = auto_reload ? RUN : DONE;
            end else begin
                cout_d  = cout_q - COUNT_W'(1);
                state_d = RUN;
            end
        end else if (!enable && state_q == RUN) begin
            state_d = ARMED;
        end
        busy_d = (state_d == ARMED) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            cout_q   <= RST_V;
            reload_q <= RST_V;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cout_q   <= cout_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cout = cout_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_countdown_timer_9bit.sv
// tb_countdown_timer_9bit: scoreboard bench; a behavioural model pushes the
// expected {cout,tc,busy,done} per driven cycle, popped after the clock edge.
module tb_countdown_timer_9bit;
    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       load = 1'b0;
    logic [8:0] load_val = '0;
    logic       enable = 1'b0;
    logic       auto_reload = 1'b0;
    logic [8:0] cout;
    logic       tc, busy, done;

    int n_chk = 0;
    int n_fail = 0;
    int tc_cnt;

    logic [11:0] sb_q[$];
    int          m_cout, m_rel, m_st;

    countdown_timer_9bit #(.MAX_COUNT(200), .RESET_VAL(0)) dut (
        .clk(clk), .clear_n(clear_n), .load(load), .load_val(load_val),
        .enable(enable), .auto_reload(auto_reload),
        .cout(cout), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cout = 0;
        m_rel  = 0;
        m_st   = 0;
    endtask

    // One clock: drive at negedge, push model prediction, compare after posedge.
    task automatic cyc(input logic l, input int val, input logic e, input logic a);
        logic [11:0] exp_v, got_v;
        int          t;
        @(negedge clk);
        load = l; load_val = 9'(val); enable = e; auto_reload = a;
        t = 0;
        if (l) begin
            m_rel  = (val > 200) ? 200 : val;
            m_cout = m_rel;
            m_st   = (m_rel != 0) ? 1 : 0;
        end else if (e && (m_st == 1 || m_st == 2)) begin
            if (m_cout == 1) begin
                t = 1;
                if (a) begin m_cout = m_rel; m_st = 2; end
                else begin m_cout = 0; m_st = 3; end
            end else begin
                m_cout = m_cout - 1;
                m_st   = 2;
            end
        end else if (!e && m_st == 2) begin
            m_st = 1;
        end
        sb_q.push_back({9'(m_cout), t[0], (m_st == 1 || m_st == 2), (m_st == 3)});
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        got_v = {cout, tc, busy, done};
        check("cout", int'(got_v[11:3]), int'(exp_v[11:3]));
        check("tc",   int'(got_v[2]),    int'(exp_v[2]));
        check("busy", int'(got_v[1]),    int'(exp_v[1]));
        check("done", int'(got_v[0]),    int'(exp_v[0]));
        if (tc) tc_cnt++;
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_cout", int'(cout), 0);
        check("reset_flags", int'({tc, busy, done}), 0);
        @(negedge clk);
        clear_n = 1'b1;

        // 1: async reset mid-count
        cyc(1, 100, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
        check("t1_cout90", int'(cout), 90);
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        check("t1_async_cout", int'(cout), 0);
        check("t1_async_flags", int'({tc, busy, done}), 0);
        model_reset();
        @(negedge clk);
        clear_n = 1'b1;
        load = 1'b0; enable = 1'b0;

        // 2: one-shot
        cyc(1, 5, 0, 0);
        check("t2_load", int'(cout), 5);
        tc_cnt = 0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        check("t2_no_tc_yet", tc_cnt, 0);
        cyc(0, 0, 1, 0);
        check("t2_tc", int'(tc), 1);
        check("t2_done", int'({busy, done}), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        check("t2_stuck0", int'(cout), 0);

        // 3: auto-reload period 3
        cyc(1, 3, 0, 1);
        tc_cnt = 0;
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1);
        check("t3_tc_pulses", tc_cnt, 4);
        check("t3_not_done", int'(done), 0);

        // 4: pause and resume
        cyc(1, 10, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        check("t4_hold", int'(cout), 6);
        check("t4_busy", int'(busy), 1);
        cyc(0, 0, 1, 0);
        check("t4_resume", int'(cout), 5);

        // 5: load/enable collision, clamp, zero load
        cyc(1, 10, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        check("t5_at7", int'(cout), 7);
        cyc(1, 300, 1, 0);
        check("t5_clamp", int'(cout), 200);
        check("t5_clamp_tc", int'(tc), 0);
        cyc(1, 0, 1, 0);
        check("t5_zero_idle", int'({busy, done}), 0);
        cyc(0, 0, 1, 0);
        check("t5_idle_hold", int'(cout), 0);

        // 6: N=1 auto-reload then drop auto_reload
        cyc(1, 1, 0, 1);
        tc_cnt = 0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1);
        check("t6_tc_every", tc_cnt, 5);
        cyc(0, 0, 1, 0);
        check("t6_final", int'({cout, done}), 1);

        // collision with a randomised period sweep
        for (int k = 0; k < 6; k++) begin
            cyc(1, int'($urandom_range(0, 511)), 0, $urandom_range(0, 1) == 1);
            for (int i = 0; i < 8; i++)
                cyc($urandom_range(0, 9) == 0, int'($urandom_range(0, 20)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
